audio_dac_serializer: RTL and testbench

Stereo I2S transmit stage fed by the audio clock generator. Runs in the 18.432 MHz reference domain and oversamples the generator's BCLK and LRCK outputs. Accepts one 16-bit stereo sample pair per frame through a valid/ready handshake and buffers one pair ahead. Shifts the samples MSB-first onto the codec DAC data line.

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_edge_det.sv | 28 ++
 rtl/audio_dac_serializer.sv | 102 ++++++++++
 tb/tb_audio_dac_serializer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared widths and sample types for the audio datapath.
// Slot width is data width plus two trailing zero bits.
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;
    localparam int AUDIO_SLOT_W = 18;

    typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t l;
        audio_sample_t r;
    } audio_pair_t;

endpackage

// File: rtl/audio_edge_det.sv
// audio_edge_det: registers an oversampled clock-domain-synchronous signal
// and emits registered rise, fall and change pulses.
module audio_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall,
    output logic chg
);

    logic q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            chg  <= 1'b0;
        end else begin
            q    <= sig;
            rise <= sig & ~q;
            fall <= q & ~sig;
            chg  <= q ^ sig;
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: I2S transmit stage with a one-pair holding buffer.
// Define AUDIO_SER_HOLD_EN to repeat the last pair on underrun instead of silence.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_W,
    parameter int SLOT_WIDTH = AUDIO_SLOT_W
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST,
    input  logic                  iBCLK,
    input  logic                  iLRCK,
    input  logic [DATA_WIDTH-1:0] iL_DATA,
    input  logic [DATA_WIDTH-1:0] iR_DATA,
    input  logic                  iVALID,
    output logic                  oREADY,
    output logic                  oDACDAT,
    output logic                  oUNDERRUN
);

    localparam logic [4:0] K_DATA = 5'(DATA_WIDTH);
    localparam logic [4:0] K_LAST = 5'(SLOT_WIDTH - 1);

    logic                  bclk_fall;
    logic [1:0]            unused_bclk;
    logic                  lrck_rise;
    logic                  lrck_fall;
    logic                  lrck_chg;
    logic                  full;
    logic                  accept;
    audio_pair_t           hold;
    audio_pair_t           work;
    logic [4:0]            k;
    logic                  ch;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] shifted;

    audio_edge_det u_bclk (
        .clk  (iCLK_18_4),
        .rst  (iRST),
        .sig  (iBCLK),
        .rise (unused_bclk[0]),
        .fall (bclk_fall),
        .chg  (unused_bclk[1])
    );

    audio_edge_det u_lrck (
        .clk  (iCLK_18_4),
        .rst  (iRST),
        .sig  (iLRCK),
        .rise (lrck_rise),
        .fall (lrck_fall),
        .chg  (lrck_chg)
    );

    assign oREADY = ~full;
    assign accept = iVALID & ~full;

    // A load in the same cycle as an accept sees the buffer empty.
    always_ff @(posedge iCLK_18_4 or posedge iRST) begin
        if (iRST) begin
            full      <= 1'b0;
            hold      <= '0;
            work      <= '0;
            oUNDERRUN <= 1'b0;
        end else begin
            oUNDERRUN <= lrck_fall & ~full;
            if (accept) begin
                hold <= '{l: iL_DATA, r: iR_DATA};
                full <= 1'b1;
            end else if (lrck_fall) begin
                full <= 1'b0;
            end
`ifdef AUDIO_SER_HOLD_EN
            if (lrck_fall && full) work <= hold;
`else
            if (lrck_fall) work <= full ? hold : '0;
`endif
        end
    end

    always_comb begin
        word    = ch ? work.r : work.l;
        shifted = word << k;
    end

    // k saturates so stray BCLK edges only pad the slot tail with zeros.
    always_ff @(posedge iCLK_18_4 or posedge iRST) begin
        if (iRST) begin
            k       <= '0;
            ch      <= 1'b0;
            oDACDAT <= 1'b0;
        end else if (lrck_chg) begin
            k  <= '0;
            ch <= lrck_rise;
        end else if (bclk_fall) begin
            oDACDAT <= (k < K_DATA) & shifted[DATA_WIDTH-1];
            if (k != K_LAST) k <= k + 5'd1;
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: table vectors, hand corner sequences and random
// traffic checked against a frame-level model of the I2S stream.
module tb_audio_dac_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bclk;
    logic        lrck;
    logic        valid;
    logic [15:0] ldat;
    logic [15:0] rdat;
    logic        ready;
    logic        dacdat;
    logic        und;

    always #5 clk = ~clk;

    audio_dac_serializer dut (
        .iCLK_18_4 (clk),
        .iRST      (rst),
        .iBCLK     (bclk),
        .iLRCK     (lrck),
        .iL_DATA   (ldat),
        .iR_DATA   (rdat),
        .iVALID    (valid),
        .oREADY    (ready),
        .oDACDAT   (dacdat),
        .oUNDERRUN (und)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [35:0] act,
                       input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Clock generator: 4 clocks per BCLK, 36 BCLKs per frame.
    int          cnt = 0;
    int          ld_cnt = 0;
    int          lf_cnt = 0;
    int          loads = 0;
    int          accepts = 0;
    int          frames = 0;
    logic        m_full = 1'b0;
    logic [15:0] m_hl = '0;
    logic [15:0] m_hr = '0;
    logic [15:0] m_cl = '0;
    logic [15:0] m_cr = '0;
    logic        exp_und = 1'b0;
    logic        acc_flag = 1'b0;
    logic [35:0] cap = '0;
    logic [35:0] last_frame = '0;

    always @(posedge clk) begin
        logic acc;
        logic new_l;
        if (rst) begin
            m_full = 1'b0;
            m_hl = '0;
            m_hr = '0;
            m_cl = '0;
            m_cr = '0;
            exp_und = 1'b0;
            ld_cnt = 0;
            acc_flag = 1'b0;
        end else begin
            acc = valid && !m_full;
            exp_und = 1'b0;
            if (ld_cnt == 1) begin
                loads++;
                if (m_full) begin
                    m_cl = m_hl;
                    m_cr = m_hr;
                    m_full = 1'b0;
                end else begin
                    exp_und = 1'b1;
`ifndef AUDIO_SER_HOLD_EN
                    m_cl = '0;
                    m_cr = '0;
`endif
                end
            end
            if (ld_cnt > 0) ld_cnt--;
            if (acc) begin
                m_hl = ldat;
                m_hr = rdat;
                m_full = 1'b1;
                accepts++;
            end
            acc_flag = acc;
        end
        cnt++;
        #1;
        bclk = (cnt % 4) < 2;
        new_l = ((cnt / 4) % 36) >= 18;
        if (lrck && !new_l) begin
            ld_cnt = 2;
            lf_cnt++;
        end
        lrck = new_l;
    end

    // Stream position s: 0..15 left MSB first, 18..33 right, rest zero.
    always @(negedge clk) begin
        int   s;
        logic eb;
        if (!rst) begin
            chk("ready", 36'(ready), 36'(!m_full));
            chk("underrun", 36'(und), 36'(exp_und));
            if (cnt % 4 == 1) begin
                s = ((cnt / 4) + 35) % 36;
                if (s < 16) eb = m_cl[15-s];
                else if (s >= 18 && s < 34) eb = m_cr[33-s];
                else eb = 1'b0;
                chk("dacdat", 36'(dacdat), 36'(eb));
                cap[35-s] = dacdat;
                if (s == 35) begin
                    last_frame = cap;
                    frames++;
                end
            end
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int n;
        ldat = l;
        rdat = r;
        valid = 1'b1;
        n = 0;
        do begin
            wait_edge();
            n++;
        end while (!acc_flag && n < 2000);
        valid = 1'b0;
        chk("accept", 36'(acc_flag), 36'd1);
    endtask

    task automatic wait_frames(input int n);
        int tgt;
        int k;
        tgt = frames + n;
        k = 0;
        while (frames < tgt && k < 400 * n) begin
            wait_edge();
            k++;
        end
        chk("frame_wait", 36'(frames >= tgt), 36'd1);
    endtask

    task automatic wait_b(input int b);
        int k;
        k = 0;
        while (((cnt / 4) % 36) != b && k < 400) begin
            wait_edge();
            k++;
        end
        chk("wait_b", 36'(((cnt / 4) % 36) == b), 36'd1);
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [35:0] exp;
    } vec_t;

    vec_t tv[5];

    initial begin
        int l0;
        int a0;
        int nu;
        int k;
        tv[0] = '{16'hA55A, 16'h0F0F,
                  36'b1010010101011010_00_0000111100001111_00};
        tv[1] = '{16'h8000, 16'h7FFF,
                  36'b1000000000000000_00_0111111111111111_00};
        tv[2] = '{16'hFFFF, 16'h0001,
                  36'b1111111111111111_00_0000000000000001_00};
        tv[3] = '{16'h0000, 16'hFFFF,
                  36'b0000000000000000_00_1111111111111111_00};
        tv[4] = '{16'h1234, 16'hCDEF,
                  36'b0001001000110100_00_1100110111101111_00};

        rst = 1'b1;
        valid = 1'b0;
        ldat = '0;
        rdat = '0;
        bclk = 1'b1;
        lrck = 1'b0;
        repeat (3) wait_edge();
        chk("rst_dacdat", 36'(dacdat), 36'd0);
        chk("rst_ready", 36'(ready), 36'd1);
        chk("rst_underrun", 36'(und), 36'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send(tv[i].l, tv[i].r);
            wait_frames(2);
            chk($sformatf("vec%0d_frame", i), last_frame, tv[i].exp);
        end

        // MSB two clocks after the first BCLK fall of the left slot.
        wait_b(5);
        send(16'h8000, 16'h0001);
        l0 = lf_cnt;
        k = 0;
        while (lf_cnt == l0 && k < 400) begin
            wait_edge();
            k++;
        end
        while (cnt % 4 != 2 && k < 400) begin
            wait_edge();
            k++;
        end
        chk("align_found", 36'(cnt % 4 == 2), 36'd1);
        @(posedge clk);
        #1;
        chk("align_1clk", 36'(dacdat), 36'd0);
        @(posedge clk);
        #1;
        chk("align_2clk", 36'(dacdat), 36'd1);

        // Continuous valid: one pair consumed per frame.
        valid = 1'b1;
        ldat = 16'($urandom);
        rdat = 16'($urandom);
        l0 = loads;
        a0 = -1;
        for (int n = 0; n < 3000 && loads < l0 + 5; n++) begin
            wait_edge();
            if (acc_flag) begin
                ldat = 16'($urandom);
                rdat = 16'($urandom);
            end
            if (a0 < 0 && loads == l0 + 1) a0 = accepts;
        end
        valid = 1'b0;
        chk("consumed_per_frame", 36'(accepts - a0), 36'd4);

        // Idle frame: exactly one underrun pulse.
        nu = 0;
        for (int n = 0; n < 150; n++) begin
            wait_edge();
            if (und) nu++;
        end
        chk("underrun_count", 36'(nu), 36'd1);

        // Handshake on the load cycle with the buffer empty.
        k = 0;
        while ((m_full || ld_cnt != 1) && k < 400) begin
            wait_edge();
            k++;
        end
        ldat = 16'h1357;
        rdat = 16'h2468;
        valid = 1'b1;
        wait_edge();
        valid = 1'b0;
        chk("same_cycle_und", 36'(und), 36'd1);
        chk("same_cycle_acc", 36'(acc_flag), 36'd1);
        wait_frames(2);
        chk("same_cycle_frame", last_frame,
            {16'h1357, 2'b00, 16'h2468, 2'b00});

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(100, 300)) wait_edge();
            send(16'($urandom), 16'($urandom));
        end
        wait_frames(2);

        // Reset mid-slot, released while LRCK is high.
        wait_b(5);
        send(16'hFFFF, 16'hFFFF);
        l0 = loads;
        k = 0;
        while (loads == l0 && k < 400) begin
            wait_edge();
            k++;
        end
        send(16'h0F0F, 16'h0F0F);
        wait_b(8);
        chk("pre_rst_dacdat", 36'(dacdat), 36'd1);
        chk("pre_rst_ready", 36'(ready), 36'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_dacdat", 36'(dacdat), 36'd0);
        chk("mid_rst_ready", 36'(ready), 36'd1);
        chk("mid_rst_underrun", 36'(und), 36'd0);
        repeat (10) wait_edge();
        wait_b(25);
        rst = 1'b0;
        send(16'hC3C3, 16'h3C3C);
        wait_frames(2);
        chk("post_rst_frame", last_frame,
            {16'hC3C3, 2'b00, 16'h3C3C, 2'b00});
        wait_frames(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
